// File: rtl/uart_fifo_bridge_pkg.sv
// Shared constants and types for the UART FIFO bridge.
// Package name is uart_bridge_pkg; it is imported by the interface users and the top.
package uart_bridge_pkg;

  // Default register window
  localparam logic [31:0] DATA_ADDR_DEF   = 32'h1001_0000;
  localparam logic [31:0] STATUS_ADDR_DEF = 32'h1001_0005;
  localparam logic [31:0] BAUD_ADDR_DEF   = 32'h1001_0100;
  localparam logic [31:0] IE_ADDR         = 32'h1001_0004;
  localparam logic [15:0] BAUD_RESET_DEF  = 16'h0003;

  // STATUS register bit positions
  localparam int ST_RX_NOT_EMPTY = 0;
  localparam int ST_RX_FULL      = 1;
  localparam int ST_TX_EMPTY     = 2;
  localparam int ST_TX_FULL      = 3;
  localparam int ST_RX_OVF       = 4;
  localparam int ST_TX_OVF       = 5;
  localparam int ST_TX_BUSY      = 6;

  // Cycles to wait for the Uart to raise busy after a launch
  localparam int START_TIMEOUT = 4;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE} tx_state_t;

endpackage

// File: rtl/uart_fifo_bridge_if.sv
// Core-bus and Uart-side signals of the bridge.
// slave = bridge view, master = core/Uart (testbench) view.
interface uart_fifo_bridge_if;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        write_enable;
  logic        read_enable;
  logic [31:0] read_data;
  logic        hit;
  logic [7:0]  uart_data;
  logic        uart_write_enable;
  logic        uart_busy;
  logic [7:0]  uart_rx_data;
  logic        uart_out_valid;
  logic        uart_negate_read_ready;
  logic [15:0] baud_max;
  logic        irq;

  modport slave (
    input  address, write_data, write_enable, read_enable,
           uart_busy, uart_rx_data, uart_out_valid,
    output read_data, hit, uart_data, uart_write_enable,
           uart_negate_read_ready, baud_max, irq
  );

  modport master (
    output address, write_data, write_enable, read_enable,
           uart_busy, uart_rx_data, uart_out_valid,
    input  read_data, hit, uart_data, uart_write_enable,
           uart_negate_read_ready, baud_max, irq
  );
endinterface

// File: rtl/uart_fifo_bridge_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; push while full succeeds only
// when a real pop happens in the same cycle. Pop on empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [AW:0]      r_wptr, r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push, w_do_pop;

  assign empty     = (r_wptr == r_rptr);
  assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = r_mem[r_rptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + ONE;
      if (w_do_pop)  r_rptr <= r_rptr + ONE;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/uart_fifo_bridge.sv
// Memory-mapped front end to the Uart: TX/RX byte FIFOs, STATUS, BAUD.
// Optional interrupt-enable register and irq output under `UART_IRQ_EN.
module uart_fifo_bridge
  import uart_bridge_pkg::*;
#(
  parameter int          DEPTH       = 8,
  parameter logic [31:0] DATA_ADDR   = DATA_ADDR_DEF,
  parameter logic [31:0] STATUS_ADDR = STATUS_ADDR_DEF,
  parameter logic [31:0] BAUD_ADDR   = BAUD_ADDR_DEF,
  parameter logic [15:0] BAUD_RESET  = BAUD_RESET_DEF
) (
  input  logic               clk,
  input  logic               rst,
  uart_fifo_bridge_if.slave  bus
);
  localparam int TO_W = $clog2(START_TIMEOUT + 1);

  tx_state_t       r_state, w_next;
  logic [TO_W-1:0] r_to_cnt;
  logic [7:0]      r_uart_data;
  logic [15:0]     r_baud;
  logic            r_tx_ovf, r_rx_ovf;

  logic       w_sel_data, w_sel_stat, w_sel_baud;
  logic       w_tx_push, w_tx_pop, w_tx_full, w_tx_empty, w_tx_ovf;
  logic       w_rx_push, w_rx_pop, w_rx_full, w_rx_empty, w_rx_ovf;
  logic [7:0] w_tx_dout, w_rx_dout;
  logic       w_launch, w_stat_rd;
  logic [6:0] w_status;
  logic       w_unused_bits;

  assign w_sel_data = (bus.address == DATA_ADDR);
  assign w_sel_stat = (bus.address == STATUS_ADDR);
  assign w_sel_baud = (bus.address == BAUD_ADDR);

  assign w_tx_push = bus.write_enable && w_sel_data;
  assign w_tx_pop  = w_launch;
  assign w_tx_ovf  = w_tx_push && w_tx_full && !w_tx_pop;

  assign w_rx_push = bus.uart_out_valid;
  assign w_rx_pop  = bus.read_enable && w_sel_data && !w_rx_empty;
  assign w_rx_ovf  = w_rx_push && w_rx_full && !w_rx_pop;

  assign w_stat_rd = bus.read_enable && w_sel_stat;
  assign w_unused_bits = ^bus.write_data[31:16];

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(w_tx_push), .pop(w_tx_pop),
    .din(bus.write_data[7:0]), .dout(w_tx_dout), .full(w_tx_full), .empty(w_tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(w_rx_push), .pop(w_rx_pop),
    .din(bus.uart_rx_data), .dout(w_rx_dout), .full(w_rx_full), .empty(w_rx_empty)
  );

  // TX FSM state, start-timeout counter and last launched byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_to_cnt    <= '0;
      r_uart_data <= '0;
    end else begin
      r_state  <= w_next;
      r_to_cnt <= (r_state == WAIT_START) ? r_to_cnt + TO_W'(1) : '0;
      if (w_launch) r_uart_data <= w_tx_dout;
    end
  end

  // TX FSM next state and launch strobe
  always_comb begin
    w_next   = r_state;
    w_launch = 1'b0;
    case (r_state)
      IDLE:       if (!w_tx_empty) w_next = LAUNCH;
      LAUNCH: begin
        w_launch = 1'b1;
        w_next   = WAIT_START;
      end
      // Uart missed the launch if busy never shows up; give up on the byte
      WAIT_START: if (bus.uart_busy)                            w_next = WAIT_DONE;
                  else if (r_to_cnt == TO_W'(START_TIMEOUT-1))  w_next = IDLE;
      WAIT_DONE:  if (!bus.uart_busy) w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  // Sticky overflow flags; a new overflow beats a same-cycle STATUS clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_ovf <= 1'b0;
      r_rx_ovf <= 1'b0;
    end else begin
      r_tx_ovf <= w_tx_ovf || (r_tx_ovf && !w_stat_rd);
      r_rx_ovf <= w_rx_ovf || (r_rx_ovf && !w_stat_rd);
    end
  end

  // Baud divisor register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               r_baud <= BAUD_RESET;
    else if (bus.write_enable && w_sel_baud) r_baud <= bus.write_data[15:0];
  end

  assign w_status[ST_RX_NOT_EMPTY] = !w_rx_empty;
  assign w_status[ST_RX_FULL]      = w_rx_full;
  assign w_status[ST_TX_EMPTY]     = w_tx_empty;
  assign w_status[ST_TX_FULL]      = w_tx_full;
  assign w_status[ST_RX_OVF]       = r_rx_ovf;
  assign w_status[ST_TX_OVF]       = r_tx_ovf;
  assign w_status[ST_TX_BUSY]      = (r_state != IDLE) || bus.uart_busy;

  assign bus.uart_data              = w_launch ? w_tx_dout : r_uart_data;
  assign bus.uart_write_enable      = w_launch;
  assign bus.uart_negate_read_ready = bus.uart_out_valid && rst;
  assign bus.baud_max               = r_baud;

`ifdef UART_IRQ_EN
  logic       w_sel_ie;
  logic [1:0] r_ie;
  logic       r_irq;

  assign w_sel_ie = (bus.address == IE_ADDR);

  // Interrupt-enable register: bit0 rx not empty, bit1 tx drained
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              r_ie <= 2'b00;
    else if (bus.write_enable && w_sel_ie) r_ie <= bus.write_data[1:0];
  end

  // Registered interrupt request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_irq <= 1'b0;
    else      r_irq <= (r_ie[0] && !w_rx_empty) ||
                       (r_ie[1] && w_tx_empty && (r_state == IDLE));
  end

  assign bus.irq = r_irq;
  assign bus.hit = w_sel_data || w_sel_stat || w_sel_baud || w_sel_ie;
`else
  assign bus.irq = 1'b0;
  assign bus.hit = w_sel_data || w_sel_stat || w_sel_baud;
`endif

  // Register read mux, combinational on address
  always_comb begin
    bus.read_data = 32'h0;
    if (w_sel_data)      bus.read_data = {24'h0, (w_rx_empty ? 8'h00 : w_rx_dout)};
    else if (w_sel_stat) bus.read_data = {25'h0, w_status};
    else if (w_sel_baud) bus.read_data = {16'h0, r_baud};
`ifdef UART_IRQ_EN
    else if (w_sel_ie)   bus.read_data = {30'h0, r_ie};
`endif
  end
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge with TX/RX byte scoreboards and a Uart busy model.
module tb_uart_fifo_bridge;
  import uart_bridge_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_fifo_bridge_if ui();

  uart_fifo_bridge dut (.clk(clk), .rst(rst), .bus(ui.slave));

  int         total = 0;
  int         bad   = 0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  int         mode = 2;      // 0 responsive busy, 1 busy held high, 2 busy never rises
  int         n_launch = 0;
  logic       model_busy = 1'b0;

  // The Uart is reset with the bridge, so its busy line drops with rst
  assign ui.uart_busy = model_busy & rst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Busy model: rises one cycle after a launch, held for 10 cycles
  int hold = 0;
  bit pend = 0;
  always @(negedge clk) begin
    if (mode == 0) begin
      if (pend) begin
        model_busy = 1'b1;
        hold = 10;
        pend = 0;
      end else if (hold > 0) begin
        hold = hold - 1;
      end
      if (!pend && hold == 0) model_busy = 1'b0;
      if (ui.uart_write_enable) pend = 1;
    end else begin
      pend = 0;
      hold = 0;
      model_busy = (mode == 1);
    end
  end

  // TX monitor: every launch must carry the next queued byte
  always @(negedge clk) begin
    if (rst && ui.uart_write_enable) begin
      logic [31:0] exp;
      n_launch++;
      exp = (txq.size() > 0) ? {24'h0, txq.pop_front()} : 32'hDEAD_BEEF;
      chk("tx_launch_byte", {24'h0, ui.uart_data}, exp);
      if (mode == 0) chk("tx_launch_after_busy", {31'h0, ui.uart_busy}, 32'h0);
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ui.address = a; ui.write_data = d; ui.write_enable = 1'b1;
    @(posedge clk);
    #1 ui.write_enable = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    ui.address = a; ui.read_enable = 1'b1;
    #1 d = ui.read_data;
    @(posedge clk);
    #1 ui.read_enable = 1'b0;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    ui.address = a;
    #1 d = ui.read_data;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic rd_pop(input string tag);
    logic [31:0] d, exp;
    exp = (rxq.size() > 0) ? {24'h0, rxq.pop_front()} : 32'h0;
    rd(DATA_ADDR_DEF, d);
    chk(tag, d, exp);
  endtask

  task automatic rxb(input logic [7:0] b, input bit kept);
    @(negedge clk);
    ui.uart_rx_data = b; ui.uart_out_valid = 1'b1;
    #1 chk("rx_nrr_pulse", {31'h0, ui.uart_negate_read_ready}, 32'h1);
    if (kept) rxq.push_back(b);
    @(posedge clk);
    #1 ui.uart_out_valid = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] b);
    txq.push_back(b);
    wr(DATA_ADDR_DEF, {24'h0, b});
  endtask

  task automatic wait_launch(input string tag, output int cyc);
    cyc = 0;
    while (cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (ui.uart_write_enable) break;
    end
    chk(tag, {31'h0, ui.uart_write_enable}, 32'h1);
  endtask

  task automatic wait_tx_idle(input string tag, input int budget);
    logic [31:0] s;
    int cyc = 0;
    bit done = 0;
    while (cyc < budget && !done) begin
      @(negedge clk);
      peek(STATUS_ADDR_DEF, s);
      cyc++;
      if (txq.size() == 0 && s[ST_TX_BUSY] == 1'b0) done = 1;
    end
    chk(tag, {31'h0, done}, 32'h1);
  endtask

  initial begin
    logic [31:0] d;
    int n0, cyc;
    #100000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int n0, cyc;
    ui.address = '0; ui.write_data = '0; ui.write_enable = 1'b0; ui.read_enable = 1'b0;
    ui.uart_rx_data = '0; ui.uart_out_valid = 1'b0;

    // Reset
    repeat (3) @(posedge clk);
    #1 chk("rst_wen_low", {31'h0, ui.uart_write_enable}, 32'h0);
    @(negedge clk) rst = 1'b1;
    rd_chk("rst_status", STATUS_ADDR_DEF, 32'h04);
    rd_chk("rst_baud", BAUD_ADDR_DEF, 32'h03);
    chk("rst_baud_max", {16'h0, ui.baud_max}, 32'h3);
    chk("rst_irq", {31'h0, ui.irq}, 32'h0);
    chk("rst_uart_data", {24'h0, ui.uart_data}, 32'h0);
    wr(BAUD_ADDR_DEF, 32'hABCD_001B);
    chk("baud_write", {16'h0, ui.baud_max}, 32'h1B);
    rd_chk("baud_read", BAUD_ADDR_DEF, 32'h1B);

    // Decode
    peek(DATA_ADDR_DEF, d);
    chk("hit_data", {31'h0, ui.hit}, 32'h1);
    peek(32'h1001_0008, d);
    chk("other_addr_zero", d, 32'h0);
    chk("hit_other", {31'h0, ui.hit}, 32'h0);
    peek(IE_ADDR, d);
`ifdef UART_IRQ_EN
    chk("hit_ie", {31'h0, ui.hit}, 32'h1);
`else
    chk("hit_ie", {31'h0, ui.hit}, 32'h0);
`endif

    // TX burst with a responsive Uart
    mode = 0;
    n0 = n_launch;
    push_tx(8'h41); push_tx(8'h42); push_tx(8'h43);
    wait_tx_idle("tx_burst_drain", 300);
    chk("tx_burst_count", n_launch - n0, 3);
    chk("tx_data_hold", {24'h0, ui.uart_data}, 32'h43);
    rd_chk("tx_burst_status", STATUS_ADDR_DEF, 32'h04);

    // TX overflow while the Uart stays busy
    mode = 1;
    n0 = n_launch;
    push_tx(8'h10);
    wait_launch("ovf_prime_launch", cyc);
    repeat (2) @(posedge clk);
    for (int k = 0; k < 9; k++) begin
      if (k < 8) txq.push_back(8'(8'h80 + k));
      wr(DATA_ADDR_DEF, 32'(8'h80 + k));
    end
    rd_chk("tx_ovf_set", STATUS_ADDR_DEF, 32'h68);
    rd_chk("tx_ovf_clear", STATUS_ADDR_DEF, 32'h48);
    mode = 0;
    wait_tx_idle("tx_ovf_drain", 600);
    chk("tx_ovf_count", n_launch - n0, 9);
    rd_chk("tx_ovf_done", STATUS_ADDR_DEF, 32'h04);

    // RX path
    rxb(8'h55, 1);
    rd_chk("rx_not_empty", STATUS_ADDR_DEF, 32'h05);
    rxb(8'hAA, 1);
    rd_pop("rx_pop0");
    rd_pop("rx_pop1");
    rd_chk("rx_empty_status", STATUS_ADDR_DEF, 32'h04);
    rd_pop("rx_pop_empty");

    // RX full, then push and pop in the same cycle
    for (int k = 0; k < 8; k++) rxb(8'(8'h60 + k), 1);
    rd_chk("rx_full_status", STATUS_ADDR_DEF, 32'h07);
    @(negedge clk);
    ui.address = DATA_ADDR_DEF; ui.read_enable = 1'b1;
    ui.uart_rx_data = 8'h99; ui.uart_out_valid = 1'b1;
    #1 chk("rx_full_simul", ui.read_data, {24'h0, rxq.pop_front()});
    rxq.push_back(8'h99);
    @(posedge clk);
    #1 begin ui.read_enable = 1'b0; ui.uart_out_valid = 1'b0; end
    rd_chk("rx_full_no_ovf", STATUS_ADDR_DEF, 32'h07);
    rxb(8'hEE, 0);
    rd_chk("rx_ovf_set", STATUS_ADDR_DEF, 32'h17);
    rd_chk("rx_ovf_clear", STATUS_ADDR_DEF, 32'h07);
    repeat (8) rd_pop("rx_drain");
    rd_chk("rx_drained", STATUS_ADDR_DEF, 32'h04);

    // Read of an empty FIFO while a byte arrives
    @(negedge clk);
    ui.address = DATA_ADDR_DEF; ui.read_enable = 1'b1;
    ui.uart_rx_data = 8'h77; ui.uart_out_valid = 1'b1;
    #1 chk("rx_empty_simul", ui.read_data, 32'h0);
    rxq.push_back(8'h77);
    @(posedge clk);
    #1 begin ui.read_enable = 1'b0; ui.uart_out_valid = 1'b0; end
    rd_chk("rx_retained", STATUS_ADDR_DEF, 32'h05);
    rd_pop("rx_pop_retained");

    // Start timeout: busy never rises
    mode = 2;
    push_tx(8'h5A);
    wait_launch("to_launch", cyc);
    chk("tx_latency", cyc, 2);
    for (int k = 0; k < START_TIMEOUT; k++) begin
      @(negedge clk);
      peek(STATUS_ADDR_DEF, d);
      chk("to_waiting", d, 32'h44);
    end
    @(negedge clk);
    peek(STATUS_ADDR_DEF, d);
    chk("to_idle", d, 32'h04);

    // Reset during LAUNCH
    push_tx(8'h66);
    wait_launch("rstl_launch", cyc);
    #2 rst = 1'b0;
    #1 chk("rst_launch_wen", {31'h0, ui.uart_write_enable}, 32'h0);
    @(negedge clk) rst = 1'b1;
    rd_chk("rst_launch_status", STATUS_ADDR_DEF, 32'h04);

    // Reset during WAIT_DONE
    mode = 1;
    push_tx(8'h33);
    wait_launch("rstw_launch", cyc);
    repeat (3) @(negedge clk);
    peek(STATUS_ADDR_DEF, d);
    chk("wd_busy", d, 32'h44);
    #2 rst = 1'b0;
    #1 chk("rst_wd_wen", {31'h0, ui.uart_write_enable}, 32'h0);
    peek(STATUS_ADDR_DEF, d);
    chk("rst_wd_status", d, 32'h04);
    chk("rst_wd_baud", {16'h0, ui.baud_max}, 32'h3);
    mode = 2;
    @(negedge clk) rst = 1'b1;
    rd_chk("post_rst_status", STATUS_ADDR_DEF, 32'h04);

    chk("txq_empty", txq.size(), 0);
    chk("rxq_empty", rxq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
